// File: rtl/mips_isa_pkg.sv
// ============================================================================
// mips_isa_pkg : MIPS opcode/funct constants, request kinds, word encoder
// Revision 1.0
// ============================================================================
`default_nettype none

package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'd1;
    localparam logic [5:0] OP_LW       = 6'd2;
    localparam logic [5:0] OP_SW       = 6'd3;
    localparam logic [4:0] SHAMT_RTYPE = 5'd10;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_MUL = 6'd50;

    typedef enum logic [2:0] {
        KIND_ADD     = 3'd0,
        KIND_SUB     = 3'd1,
        KIND_AND     = 3'd2,
        KIND_OR      = 3'd3,
        KIND_MUL     = 3'd4,
        KIND_LW      = 3'd5,
        KIND_SW      = 3'd6,
        KIND_INVALID = 3'd7
    } req_kind_e;

    // rd is unused by I-type words; invalid kinds encode to zero
    function automatic logic [31:0] encode_instr(
        input req_kind_e   kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word = 32'd0;
        case (kind)
            KIND_ADD: word = {OP_RTYPE, rs, rt, rd, SHAMT_RTYPE, FUNCT_ADD};
            KIND_SUB: word = {OP_RTYPE, rs, rt, rd, SHAMT_RTYPE, FUNCT_SUB};
            KIND_AND: word = {OP_RTYPE, rs, rt, rd, SHAMT_RTYPE, FUNCT_AND};
            KIND_OR:  word = {OP_RTYPE, rs, rt, rd, SHAMT_RTYPE, FUNCT_OR};
            KIND_MUL: word = {OP_RTYPE, rs, rt, rd, SHAMT_RTYPE, FUNCT_MUL};
            KIND_LW:  word = {OP_LW, rs, rt, imm};
            KIND_SW:  word = {OP_SW, rs, rt, imm};
            default:  word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// ============================================================================
// instr_encoder_if : request handshake and instruction-memory write bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface instr_encoder_if
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    req_kind_e         req_kind;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [15:0]       req_imm;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    // master: boot loader / memory side; slave: the encoder
    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// instr_fifo : synchronous FIFO with flush, occupancy count and async reset
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     flush,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full & ~flush;
    assign w_do_pop  = pop & ~empty & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : encodes symbolic requests into MIPS words and loads them
//                 sequentially into instruction memory through a FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              finish,
    instr_encoder_if.slave         bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        instr_count,
    output logic                   err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] C_CAPACITY = {2'b01, {ADDR_W{1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic              w_req_ready;
    logic              w_xfer_state;
    logic              w_mem_we;
    logic              w_accept;
    logic              w_kind_bad;
    logic              w_overflow;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_word;
    logic [ADDR_W+1:0] w_total;

    logic [31:0]       w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  if (finish) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_fifo_empty) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_xfer_state = 1'b0;
        w_req_ready  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_xfer_state = 1'b1;
                w_req_ready  = ~w_fifo_full;
                busy         = 1'b1;
            end
            S_DRAIN: begin
                w_xfer_state = 1'b1;
                busy         = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    // Words written plus words still buffered may never exceed the address space
    assign w_total    = {1'b0, r_count} + (ADDR_W + 2)'(w_fifo_count);
    assign w_overflow = (w_total == C_CAPACITY);
    assign w_kind_bad = (bus.req_kind == KIND_INVALID);
    assign w_accept   = bus.req_valid & w_req_ready;
    assign w_push     = w_accept & ~w_kind_bad & ~w_overflow & ~start;
    assign w_mem_we   = w_xfer_state & ~w_fifo_empty;
    assign w_pop      = w_mem_we & bus.mem_ready & ~start;
    assign w_word     = encode_instr(bus.req_kind, bus.req_rs, bus.req_rt,
                                     bus.req_rd, bus.req_imm);

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_word),
        .rdata (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= C_BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (start) begin
            r_addr  <= C_BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
            end
            if (w_accept && (w_kind_bad || w_overflow)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_mem_we ? w_fifo_head : 32'd0;
    assign instr_count   = r_count;
    assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// tb_instr_encoder : directed and random stimulus for two encoder instances
//                    (ADDR_W=8 and ADDR_W=2) against a queue-based model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;
    import mips_isa_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  kind_v = 3'd0;
    logic [4:0]  rs_v = 5'd0, rt_v = 5'd0, rd_v = 5'd0;
    logic [15:0] imm_v = 16'd0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(8)) ifa ();
    instr_encoder_if #(.ADDR_W(2)) ifb ();

    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [8:0] cnt_a;
    logic [2:0] cnt_b;

    assign ifa.req_valid = req_valid;
    assign ifa.req_kind  = req_kind_e'(kind_v);
    assign ifa.req_rs    = rs_v;
    assign ifa.req_rt    = rt_v;
    assign ifa.req_rd    = rd_v;
    assign ifa.req_imm   = imm_v;
    assign ifa.mem_ready = mem_ready;
    assign ifb.req_valid = req_valid;
    assign ifb.req_kind  = req_kind_e'(kind_v);
    assign ifb.req_rs    = rs_v;
    assign ifb.req_rt    = rt_v;
    assign ifb.req_rd    = rd_v;
    assign ifb.req_imm   = imm_v;
    assign ifb.mem_ready = mem_ready;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .finish(finish), .bus(ifa),
        .busy(busy_a), .done(done_a), .instr_count(cnt_a), .err(err_a)
    );

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .finish(finish), .bus(ifb),
        .busy(busy_b), .done(done_b), .instr_count(cnt_b), .err(err_b)
    );

    // Observed outputs gathered per instance for uniform checking
    logic        o_rdy[2], o_we[2], o_busy[2], o_done[2], o_err[2];
    logic [31:0] o_addr[2], o_data[2], o_cnt[2];
    assign o_rdy[0] = ifa.req_ready;  assign o_rdy[1] = ifb.req_ready;
    assign o_we[0]  = ifa.mem_we;     assign o_we[1]  = ifb.mem_we;
    assign o_addr[0] = {24'd0, ifa.mem_addr};
    assign o_addr[1] = {30'd0, ifb.mem_addr};
    assign o_data[0] = ifa.mem_wdata; assign o_data[1] = ifb.mem_wdata;
    assign o_cnt[0] = {23'd0, cnt_a}; assign o_cnt[1] = {29'd0, cnt_b};
    assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;
    assign o_done[0] = done_a; assign o_done[1] = done_b;
    assign o_err[0]  = err_a;  assign o_err[1]  = err_b;

    // Reference model: phase 0 idle, 1 loading, 2 draining, 3 done
    logic [31:0] q[2][$];
    wr_t         wlog[2][$];
    int          phase[2];
    int          wr_n[2];
    bit          m_err[2];
    int          cap[2];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_word(input int k, input int rs, input int rt,
                                             input int rd, input int imm);
        longint w;
        int     funct;
        case (k)
            0: funct = 32;
            1: funct = 34;
            2: funct = 36;
            3: funct = 37;
            default: funct = 50;
        endcase
        if (k < 5)       w = 64'd1 * (2**26) + rs * (2**21) + rt * (2**16) + rd * (2**11) + 10 * 64 + funct;
        else if (k == 5) w = 64'd2 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        else             w = 64'd3 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        return w[31:0];
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            string       p;
            bit          e_we, e_rdy;
            int          sz, wn;
            logic [31:0] e_data;
            p = (d == 0) ? "A" : "B";
            if (!rst_n) begin
                q[d].delete();
                wr_n[d]  = 0;
                m_err[d] = 1'b0;
                phase[d] = 0;
            end
            sz     = q[d].size();
            wn     = wr_n[d];
            e_we   = (phase[d] == 1 || phase[d] == 2) && sz > 0;
            e_rdy  = (phase[d] == 1) && sz < DEPTH;
            e_data = e_we ? q[d][0] : 32'd0;
            chk({p, ".req_ready"}, {31'd0, o_rdy[d]}, {31'd0, e_rdy});
            chk({p, ".mem_we"},    {31'd0, o_we[d]},  {31'd0, e_we});
            chk({p, ".mem_wdata"}, o_data[d], e_data);
            chk({p, ".mem_addr"},  o_addr[d], wn % cap[d]);
            chk({p, ".instr_count"}, o_cnt[d], wn);
            chk({p, ".err"},  {31'd0, o_err[d]},  {31'd0, m_err[d]});
            chk({p, ".busy"}, {31'd0, o_busy[d]}, {31'd0, (phase[d] == 1 || phase[d] == 2)});
            chk({p, ".done"}, {31'd0, o_done[d]}, {31'd0, (phase[d] == 3)});
            if (rst_n) begin
                if (start_v[d]) begin
                    q[d].delete();
                    wr_n[d]  = 0;
                    m_err[d] = 1'b0;
                    phase[d] = 1;
                end else begin
                    if (e_we && mem_ready) begin
                        wlog[d].push_back('{cyc, wn % cap[d], q[d][0]});
                        void'(q[d].pop_front());
                        wr_n[d]++;
                    end
                    if (e_rdy && req_valid) begin
                        if (kind_v == 3'd7)           m_err[d] = 1'b1;
                        else if (wn + sz == cap[d])   m_err[d] = 1'b1;
                        else q[d].push_back(ref_word(int'(kind_v), int'(rs_v), int'(rt_v),
                                                     int'(rd_v), int'(imm_v)));
                    end
                    if (phase[d] == 1 && finish)      phase[d] = 2;
                    else if (phase[d] == 2 && sz == 0) phase[d] = 3;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(input int k, input int rs, input int rt, input int rd, input int imm);
        req_valid = 1'b1;
        kind_v = 3'(k);
        rs_v = 5'(rs); rt_v = 5'(rt); rd_v = 5'(rd);
        imm_v = 16'(imm);
    endtask

    task automatic pulse_start(input logic [1:0] which);
        start_v = which;
        step();
        start_v = 2'b00;
    endtask

    initial begin
        cap[0] = 256;
        cap[1] = 4;
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0; wr_n[d] = 0; m_err[d] = 1'b0;
        end

        // Reset state
        #2;
        chk("reset.mem_we", {31'd0, ifa.mem_we}, 32'd0);
        chk("reset.req_ready", {31'd0, ifa.req_ready}, 32'd0);
        chk("reset.instr_count", {23'd0, cnt_a}, 32'd0);
        steps(2);
        rst_n = 1'b1;
        steps(2);

        // Single add
        mem_ready = 1'b1;
        pulse_start(2'b01);
        set_req(0, 1, 2, 3, 0);
        step();
        req_valid = 1'b0;
        #2;
        chk("add.word", ifa.mem_wdata, 32'h04221AA0);
        chk("add.addr", {24'd0, ifa.mem_addr}, 32'd0);
        step();
        chk("add.count", {23'd0, cnt_a}, 32'd1);
        steps(2);

        // Back-to-back lw, sw, mul
        pulse_start(2'b01);
        wlog[0].delete();
        set_req(5, 4, 5, 0, 16'h0010); step();
        set_req(6, 6, 7, 0, 16'hFFFC); step();
        set_req(4, 8, 9, 10, 0);       step();
        req_valid = 1'b0;
        steps(4);
        chk("b2b.nwrites", wlog[0].size(), 3);
        if (wlog[0].size() == 3) begin
            chk("b2b.w0", wlog[0][0].data, 32'h08850010);
            chk("b2b.w1", wlog[0][1].data, 32'h0CC7FFFC);
            chk("b2b.w2", wlog[0][2].data, 32'h050952B2);
            chk("b2b.a2", wlog[0][2].addr, 2);
            chk("b2b.consecutive", wlog[0][2].cyc - wlog[0][0].cyc, 2);
        end

        // Backpressure: 5 requests against a stalled memory
        mem_ready = 1'b0;
        pulse_start(2'b01);
        wlog[0].delete();
        for (int i = 0; i < 5; i++) begin
            set_req(i % 4, i + 1, i + 2, i + 3, 0);
            step();
        end
        req_valid = 1'b0;
        chk("full.req_ready", {31'd0, ifa.req_ready}, 32'd0);
        chk("full.mem_we", {31'd0, ifa.mem_we}, 32'd1);
        mem_ready = 1'b1;
        steps(6);
        chk("full.nwrites", wlog[0].size(), 4);

        // Invalid kind between two adds
        pulse_start(2'b01);
        wlog[0].delete();
        set_req(0, 1, 1, 1, 0); step();
        set_req(7, 2, 2, 2, 0); step();
        set_req(0, 3, 3, 3, 0); step();
        req_valid = 1'b0;
        steps(3);
        chk("inv.nwrites", wlog[0].size(), 2);
        chk("inv.err", {31'd0, err_a}, 32'd1);
        pulse_start(2'b01);
        chk("inv.err_cleared", {31'd0, err_a}, 32'd0);

        // Address-space overflow on the ADDR_W=2 instance
        pulse_start(2'b10);
        wlog[1].delete();
        for (int i = 0; i < 5; i++) begin
            set_req(1, i, i + 1, i + 2, 0);
            step();
        end
        req_valid = 1'b0;
        finish = 1'b1; step(); finish = 1'b0;
        steps(4);
        chk("ovf.nwrites", wlog[1].size(), 4);
        if (wlog[1].size() == 4) chk("ovf.last_addr", wlog[1][3].addr, 3);
        chk("ovf.err", {31'd0, err_b}, 32'd1);
        chk("ovf.done", {31'd0, done_b}, 32'd1);
        chk("ovf.count", {29'd0, cnt_b}, 32'd4);

        // Asynchronous reset with three buffered words
        mem_ready = 1'b0;
        pulse_start(2'b01);
        for (int i = 0; i < 3; i++) begin
            set_req(2, i, i, i, 0);
            step();
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst.mem_we", {31'd0, ifa.mem_we}, 32'd0);
        chk("arst.busy", {31'd0, busy_a}, 32'd0);
        chk("arst.mem_wdata", ifa.mem_wdata, 32'd0);
        mem_ready = 1'b1;
        wlog[0].delete();
        steps(2);
        rst_n = 1'b1;
        step();
        chk("arst.no_write", wlog[0].size(), 0);
        pulse_start(2'b01);
        set_req(3, 9, 9, 9, 0); step();
        req_valid = 1'b0;
        steps(2);
        chk("arst.restart_writes", wlog[0].size(), 1);
        if (wlog[0].size() == 1) chk("arst.restart_addr", wlog[0][0].addr, 0);

        // Randomised traffic on both instances
        for (int i = 0; i < 600; i++) begin
            start_v   = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
            finish    = ($urandom_range(0, 24) == 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 7) set_req($urandom_range(0, 7), $urandom_range(0, 31),
                                                  $urandom_range(0, 31), $urandom_range(0, 31),
                                                  $urandom_range(0, 65535));
            else req_valid = 1'b0;
            step();
        end
        start_v = 2'b00;
        finish = 1'b0;
        req_valid = 1'b0;
        steps(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader for the MIPS core. It is the inverse of the control decoder: it accepts symbolic operation requests (kind, registers, immediate) over a valid/ready handshake and encodes each one into a 32-bit instruction word. Encoded words are buffered in a small FIFO and written sequentially into instruction memory from a base address. It sits between the testbench or boot loader and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction memory address width (word addresses)
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)
- BASE_ADDR, 0, first write address after `start`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: clear FIFO, address, count and err; enter LOAD
- finish  in  1  pulse: stop accepting, drain FIFO, then DONE
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid && ready
- req_kind  in  3  0 add, 1 sub, 2 and, 3 or, 4 mul, 5 lw, 6 sw, 7 invalid
- req_rs / req_rt / req_rd  in  5 each  register fields
- req_imm  in  16  immediate (lw/sw only)
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in DONE
- instr_count  out  ADDR_W+1  words written since `start`
- err  out  1  sticky: invalid kind or memory overflow since `start`

## Operation
- Encoding:
  - R-type (kinds 0–4) = {6'd1, rs, rt, rd, 5'd10, funct}, funct: add 32, sub 34, and 36, or 37, mul 50.
  - lw = {6'd2, rs, rt, imm}; sw = {6'd3, rs, rt, imm}. rd is ignored for I-type.
- FSM states and transitions:
  - IDLE: after reset; req_ready=0. start → LOAD.
  - LOAD: req_ready = !fifo_full. finish → DRAIN.
  - DRAIN: req_ready=0. FIFO empty → DONE.
  - DONE: done=1. start → LOAD.
- Accepted request handling:
  - Valid kind: encoded word pushed to the FIFO.
  - Kind 7: not pushed; err set.
  - Accepted while instr_count + FIFO occupancy = 2^ADDR_W: dropped; err set. There is no address wrap.
- Write side, in LOAD and DRAIN:
  - mem_we = !fifo_empty; mem_wdata = FIFO head when mem_we, else 0.
  - Transfer on mem_we && mem_ready: pop, mem_addr += 1, instr_count += 1.
- Boundary conditions:
  - start in LOAD, DRAIN or DONE flushes the FIFO and restarts. Any in-flight word is discarded and not written.
  - start and finish in the same cycle: start wins.
  - finish in IDLE or DONE is ignored.
  - When full, req_ready=0 even if a pop occurs the same cycle (ready does not depend on mem_ready).
  - Push and pop in the same cycle while not full: both happen; occupancy unchanged.
  - mem_ready=0 holds mem_we, mem_addr and mem_wdata stable.

## Timing
- Reset values: req_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, busy 0, done 0, instr_count 0, err 0, state IDLE, FIFO empty.
- start sampled at edge N: req_ready may be 1 from cycle N+1.
- Request accepted at edge N: mem_we high with that word in cycle N+1 at earliest. The FIFO is registered, so there is no same-cycle bypass.
- Sustained throughput is one word per cycle with mem_ready tied high.
- DRAIN → DONE on the edge after the last transfer; done rises in that next cycle.
- err is set on the edge of the offending acceptance.
- Reset may assert mid-operation; all state returns to reset values asynchronously.

## Structure
- Package `mips_isa_pkg` holds:
  - Opcodes OP_RTYPE=1, OP_LW=2, OP_SW=3, SHAMT_RTYPE=10.
  - FUNCT_ADD/SUB/AND/OR/MUL constants and the req_kind enum.
  - An `encode_instr` function, shared with the control decoder's bench.
- Sub-module `instr_fifo`: synchronous FIFO, parameterised width/depth, with push, pop, full, empty, count and flush.
- FSM, counters and encoder live in the top.

## Test plan
- start; add rs=1 rt=2 rd=3 with mem_ready=1 → mem_wdata 0x04221AA0 at mem_addr 0; instr_count 1.
- lw rs=4 rt=5 imm=0x0010, sw rs=6 rt=7 imm=0xFFFC, mul rs=8 rt=9 rd=10 back-to-back → 0x08850010, 0x0CC7FFFC, 0x050952B2 at addresses 0, 1, 2 on consecutive cycles.
- mem_ready=0, push 5 requests → 4 accepted, then req_ready=0; mem outputs stable. Release mem_ready → 4 writes in order.
- Request with kind 7 between two adds → only 2 writes; err=1; a subsequent start clears err.
- ADDR_W=2: 5 requests, then finish → 4 writes at addresses 0–3; 5th dropped; err=1; done=1; instr_count=4.
- rst_n low while FIFO holds 3 words → immediate reset values, no further mem_we. start after release → writes begin at BASE_ADDR.
